demux_1_to_3: RTL and testbench

Buffered 1-to-3 result distributor: accepts a stream of 16-bit words, each tagged with a 2-bit destination select, and delivers each word, in order, to one of three consumer ports over valid/ready handshakes. It is the fan-out counterpart of the datapath's 3-to-1 operand/result selection. One producer (ALU/writeback stage) drives it. Three consumers (register file write port, memory store path, forwarding path) each receive only the words addressed to them. A small FIFO decouples producer timing from consumer backpressure, and words with an invalid select are discarded and counted.

---
 rtl/demux_1_to_3_pkg.sv | 17 +
 rtl/demux_1_to_3_if.sv | 36 +++
 rtl/demux_1_to_3_fifo.sv | 52 +++++
 rtl/demux_1_to_3.sv | 75 +++++++
 tb/tb_demux_1_to_3.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/demux_1_to_3_pkg.sv
// Shared select encodings and widths for the 1-to-3 result distributor.
package demux_1_to_3_pkg;

  localparam logic [1:0] SEL_P0   = 2'b00;
  localparam logic [1:0] SEL_P1   = 2'b01;
  localparam logic [1:0] SEL_P2   = 2'b10;
  localparam logic [1:0] SEL_DROP = 2'b11;

  localparam int DATA_W     = 16;
  localparam int DROP_CNT_W = 8;

  // Saturating increment used by the drop counter.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/demux_1_to_3_if.sv
// Producer and three consumer handshakes plus the drop counter, bundled.
// master = surrounding logic (producer/consumers), slave = the distributor.
interface demux_1_to_3_if
  import demux_1_to_3_pkg::*;
#(
  parameter int WIDTH = DATA_W
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic [1:0]            in_sel;

  logic                  out0_valid;
  logic                  out0_ready;
  logic [WIDTH-1:0]      out0_data;
  logic                  out1_valid;
  logic                  out1_ready;
  logic [WIDTH-1:0]      out1_data;
  logic                  out2_valid;
  logic                  out2_ready;
  logic [WIDTH-1:0]      out2_data;

  logic [DROP_CNT_W-1:0] drop_count;

  modport master (
    output in_valid, in_data, in_sel, out0_ready, out1_ready, out2_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data,
           out2_valid, out2_data, drop_count
  );

  modport slave (
    input  in_valid, in_data, in_sel, out0_ready, out1_ready, out2_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data,
           out2_valid, out2_data, drop_count
  );
endinterface

// File: rtl/demux_1_to_3_fifo.sv
// Synchronous FIFO holding {sel, data}; 1-cycle write-to-read latency, no bypass.
// Push is ignored when full and pop when empty; caller gates with full/empty.
module demux_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH+1:0] wdata,
  output logic [WIDTH+1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [WIDTH+1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/demux_1_to_3.sv
// Buffered 1-to-3 distributor: in-order delivery, 1-cycle minimum latency, select 11 dropped.
// in_ready depends only on FIFO fullness; a blocked head stalls all later words.
module demux_1_to_3
  import demux_1_to_3_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  demux_1_to_3_if.slave bus
);
  logic [WIDTH+1:0]      head;
  logic [1:0]            head_sel;
  logic [WIDTH-1:0]      head_data;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  drop_pop;
  logic                  v0;
  logic                  v1;
  logic                  v2;
  logic [DROP_CNT_W-1:0] drop_cnt;

  assign bus.in_ready = !full && !rst;
  assign push         = bus.in_valid && bus.in_ready;

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.in_sel, bus.in_data}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign head_sel  = head[WIDTH+1:WIDTH];
  assign head_data = head[WIDTH-1:0];

  // Valids are masked during reset so nothing is offered from a discarded head.
  always_comb begin
    v0       = 1'b0;
    v1       = 1'b0;
    v2       = 1'b0;
    pop      = 1'b0;
    drop_pop = 1'b0;
    if (!empty && !rst) begin
      case (head_sel)
        SEL_P0: begin v0 = 1'b1; pop = bus.out0_ready; end
        SEL_P1: begin v1 = 1'b1; pop = bus.out1_ready; end
        SEL_P2: begin v2 = 1'b1; pop = bus.out2_ready; end
        default: begin pop = 1'b1; drop_pop = 1'b1; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           drop_cnt <= '0;
    else if (drop_pop) drop_cnt <= sat_inc(drop_cnt);
  end

  assign bus.out0_valid = v0;
  assign bus.out1_valid = v1;
  assign bus.out2_valid = v2;
  assign bus.out0_data  = head_data;
  assign bus.out1_data  = head_data;
  assign bus.out2_data  = head_data;
  assign bus.drop_count = drop_cnt;
endmodule

// File: tb/tb_demux_1_to_3.sv
// Directed bench with a scoreboard of expected deliveries for the 1-to-3 distributor.
module tb_demux_1_to_3;
  import demux_1_to_3_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_1_to_3_if #(.WIDTH(16)) bus ();

  demux_1_to_3 #(.WIDTH(16), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one word and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic push(input logic [15:0] d, input logic [1:0] s);
    int   waited;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sel   = s;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 50) break;
    end
    if (waited > 50) begin
      chk("push_timeout", 32'd1, 32'd0);
    end else begin
      @(posedge clk);
      if (s != SEL_DROP) begin
        e.sel  = s;
        e.data = d;
        q.push_back(e);
      end
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic mon_port(input logic [1:0] k, input logic v, input logic r, input logic [15:0] d);
    exp_t e;
    if (v && r) begin
      if (q.size() == 0) begin
        chk("unexpected_word", {16'd0, d}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("deliver_port", {30'd0, k}, {30'd0, e.sel});
        chk("deliver_data", {16'd0, d}, {16'd0, e.data});
      end
    end
  endtask

  // Handshakes observed at the falling edge complete on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if ((bus.out0_valid + bus.out1_valid + bus.out2_valid) > 1)
        chk("onehot_valid", 32'd1, 32'd0);
      mon_port(2'd0, bus.out0_valid, bus.out0_ready, bus.out0_data);
      mon_port(2'd1, bus.out1_valid, bus.out1_ready, bus.out1_data);
      mon_port(2'd2, bus.out2_valid, bus.out2_ready, bus.out2_data);
    end
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_sel     = '0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    bus.out2_ready = 1'b0;

    // Reset state
    step(2);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_valids", {bus.out2_valid, bus.out1_valid, bus.out0_valid}, 0);
    chk("rst_drop_count", bus.drop_count, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Single delivery
    bus.out0_ready = 1'b1;
    push(16'h1234, SEL_P0);
    chk("single_v0", bus.out0_valid, 1);
    chk("single_d0", bus.out0_data, 32'h1234);
    chk("single_v12", {bus.out2_valid, bus.out1_valid}, 0);
    step(1);
    chk("single_empty", {bus.out2_valid, bus.out1_valid, bus.out0_valid}, 0);

    // Backpressure and order
    bus.out0_ready = 1'b0;
    push(16'hAAAA, SEL_P1);
    push(16'hBBBB, SEL_P2);
    chk("bp_full", bus.in_ready, 0);
    chk("bp_v1", bus.out1_valid, 1);
    chk("bp_d1", bus.out1_data, 32'hAAAA);
    chk("bp_v2", bus.out2_valid, 0);
    step(2);
    chk("bp_v1_hold", bus.out1_valid, 1);
    chk("bp_d1_hold", bus.out1_data, 32'hAAAA);
    bus.out1_ready = 1'b1;
    bus.out2_ready = 1'b1;
    step(1);
    chk("bp_v2_next", bus.out2_valid, 1);
    chk("bp_d2_next", bus.out2_data, 32'hBBBB);
    chk("bp_v1_done", bus.out1_valid, 0);
    step(1);
    chk("bp_empty", {bus.out2_valid, bus.out1_valid, bus.out0_valid}, 0);

    // Drop
    push(16'hDEAD, SEL_DROP);
    chk("drop_no_valid", {bus.out2_valid, bus.out1_valid, bus.out0_valid}, 0);
    step(1);
    chk("drop_count_1", bus.drop_count, 1);
    for (int i = 0; i < 260; i++) push(16'(i), SEL_DROP);
    step(2);
    chk("drop_count_sat", bus.drop_count, 255);

    // Streaming on port 2
    for (int i = 0; i < 10; i++) begin
      chk("stream_in_ready", bus.in_ready, 1);
      push(16'(i), SEL_P2);
      chk("stream_v2", bus.out2_valid, 1);
      chk("stream_d2", bus.out2_data, i);
    end
    step(1);
    chk("stream_empty", {bus.out2_valid, bus.out1_valid, bus.out0_valid}, 0);

    // Reset mid-operation with a full FIFO
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    bus.out2_ready = 1'b0;
    push(16'h1111, SEL_P0);
    push(16'h2222, SEL_P1);
    chk("mid_full", bus.in_ready, 0);
    rst = 1'b1;
    q.delete();
    #1;
    chk("mid_rst_valids", {bus.out2_valid, bus.out1_valid, bus.out0_valid}, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    step(1);
    chk("mid_rst_drop_count", bus.drop_count, 0);
    rst = 1'b0;
    #1;
    chk("mid_post_in_ready", bus.in_ready, 1);
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    bus.out2_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("mid_no_stale", {bus.out2_valid, bus.out1_valid, bus.out0_valid}, 0);
      step(1);
    end
    chk("mid_drop_count", bus.drop_count, 0);

    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
